// File: rtl/spike_rate_decoder_pkg.sv
// Shared definitions for the spike rate decoder: FSM states and sizing constants.
package spike_rate_decoder_pkg;

  // Decoder FSM: waiting for a window to start, or accumulating a window.
  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // Default width of each per-neuron spike counter.
  localparam int DEFAULT_CNT_W = 8;

  // Width of the winner index (covers up to 8 neurons).
  localparam int WIN_IDX_W = 3;

endpackage

// File: rtl/spike_argmax.sv
// Combinational argmax over NUM_NEURONS packed counts: lowest index holding the
// maximum, whether the maximum is shared, and whether every count is zero.
module spike_argmax
  import spike_rate_decoder_pkg::*;
#(
  parameter int NUM_NEURONS = 2,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic [NUM_NEURONS*CNT_W-1:0] counts,
  output logic [WIN_IDX_W-1:0]         winner,
  output logic                         tie,
  output logic                         silent
);

  logic [CNT_W-1:0] max_val;
  logic [CNT_W-1:0] cur;

  // Linear scan; strict '>' keeps the lowest index on equal counts, and an
  // all-zero window naturally yields winner=0, tie=1.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    max_val = counts[0 +: CNT_W];
    cur     = '0;
    winner  = '0;
    tie     = 1'b0;
    silent  = (counts[0 +: CNT_W] == '0);
    for (int i = 1; i < NUM_NEURONS; i++) begin
      cur = counts[i*CNT_W +: CNT_W];
      if (cur != '0) silent = 1'b0;
      if (cur > max_val) begin
        max_val = cur;
        winner  = WIN_IDX_W'(i);
        tie     = 1'b0;
      end else if (cur == max_val) begin
        tie = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Rate decoder: counts spikes per neuron over a programmable window, then
// registers the counts and their argmax into a valid/ready result slot.
module spike_rate_decoder
  import spike_rate_decoder_pkg::*;
#(
  parameter int NUM_NEURONS = 2,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic [NUM_NEURONS-1:0]       spike,
  input  logic [7:0]                   window_len,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [NUM_NEURONS*CNT_W-1:0] counts,
  output logic [WIN_IDX_W-1:0]         winner,
  output logic                         tie,
  output logic                         silent,
  output logic                         overrun
);

  state_t                       state_q, state_d;
  logic [7:0]                   len_q;
  logic [7:0]                   cyc_cnt;
  logic [NUM_NEURONS*CNT_W-1:0] cnt_q;
  logic [NUM_NEURONS*CNT_W-1:0] cnt_inc;
  logic                         start;
  logic                         snapshot;
  logic                         keep_counting;
  logic [WIN_IDX_W-1:0]         am_winner;
  logic                         am_tie;
  logic                         am_silent;

  // Saturating per-neuron increment including this cycle's spikes.
  always_comb begin
    cnt_inc = cnt_q;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (spike[i] && (cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
        cnt_inc[i*CNT_W +: CNT_W] = cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  // Argmax is taken over the counts that the snapshot will register, so the
  // summary flags land in the same edge as the counts.
  spike_argmax #(
    .NUM_NEURONS (NUM_NEURONS),
    .CNT_W       (CNT_W)
  ) u_argmax (
    .counts (cnt_inc),
    .winner (am_winner),
    .tie    (am_tie),
    .silent (am_silent)
  );

  // Next-state logic: window start, snapshot detection and abort on disable.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    snapshot = 1'b0;
    case (state_q)
      IDLE: begin
        if (ena && (window_len != 8'd0)) begin
          state_d = COUNT;
          start   = 1'b1;
        end
      end
      COUNT: begin
        if (!ena) begin
          state_d = IDLE;
        end else if (cyc_cnt == (len_q - 8'd1)) begin
          snapshot = 1'b1;
          if (window_len == 8'd0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    keep_counting = (state_q == COUNT) && ena && !snapshot;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // Window accumulation: counters and cycle counter clear on start, snapshot,
  // abort and idle; the window length is captured at every window start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the counter bank is plain flops, so it takes the async reset like
      // any other state; it is not a RAM and needs no initialisation sequence.
      cnt_q   <= '0;
      cyc_cnt <= '0;
      len_q   <= '0;
    end else begin
      if (keep_counting) begin
        cnt_q   <= cnt_inc;
        cyc_cnt <= cyc_cnt + 8'd1;
      end else begin
        cnt_q   <= '0;
        cyc_cnt <= '0;
      end
      if (start || snapshot) len_q <= window_len;
    end
  end

  // Result slot: load on snapshot, flag overwrite of an unconsumed result,
  // release on handshake when no new result arrives on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      counts    <= '0;
      winner    <= '0;
      tie       <= 1'b0;
      silent    <= 1'b0;
      overrun   <= 1'b0;
    end else if (snapshot) begin
      out_valid <= 1'b1;
      counts    <= cnt_inc;
      winner    <= am_winner;
      tie       <= am_tie;
      silent    <= am_silent;
      overrun   <= out_valid && !out_ready;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 Parameter NUM_NEURONS, default 2: number of spike inputs decoded (range 2..8).
REQ-002 Parameter CNT_W, default 8: width of each per-neuron spike counter.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 ena  input  1: design enable; low halts counting.
REQ-006 spike  input  NUM_NEURONS: spike flags from upstream LIF neurons, one bit per neuron, sampled each clock.
REQ-007 window_len  input  8: observation window length in cycles; 0 means decoder disabled.
REQ-008 out_ready  input  1: downstream accepts the result when high with out_valid.
REQ-009 out_valid  output  1: result registers hold an unconsumed window result.
REQ-010 counts  output  NUM_NEURONS*CNT_W: per-neuron spike counts of the last window; neuron i occupies bits [i*CNT_W +: CNT_W].
REQ-011 winner  output  3: index of the neuron with the highest count.
REQ-012 tie  output  1: the maximum count is shared by two or more neurons.
REQ-013 silent  output  1: all counts of the reported window are zero.
REQ-014 overrun  output  1: an unconsumed result was overwritten by this result.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and COUNT.
REQ-016 IDLE->COUNT when ena=1 and window_len!=0; on that edge, window_len is latched into len_q, cyc_cnt cleared, and counters cleared; that edge's spikes are not counted.
REQ-017 In COUNT, each edge SHALL add spike[i] to counter i and increment cyc_cnt.
REQ-018 Counters SHALL saturate at 2^CNT_W-1; no wrap-around.
REQ-019 When the edge samples the len_q-th cycle of a window (cyc_cnt==len_q-1), counts including that cycle's spikes SHALL be loaded into the output registers, out_valid SHALL be set, and counters and cyc_cnt SHALL clear.
REQ-020 Windows SHALL run back-to-back: the edge after a snapshot is the first cycle of the next window, with no dead cycle.
REQ-021 window_len changes SHALL take effect only at the next window start; len_q is reloaded at each snapshot.
REQ-022 COUNT->IDLE SHALL occur when ena=0 or when window_len=0 at a snapshot; a partial window is discarded and counters cleared; output registers are untouched.
REQ-023 Handshake: out_valid SHALL clear on an edge with out_valid=1 and out_ready=1, unless a snapshot occurs on the same edge, in which case out_valid stays 1 with the new data and overrun=0.
REQ-024 A snapshot while out_valid=1 and out_ready=0 SHALL overwrite the result and set overrun=1; otherwise a snapshot sets overrun=0.
REQ-025 counts, winner, tie, silent and overrun SHALL be stable while out_valid=1 and no snapshot occurs.
REQ-026 winner SHALL be the lowest index among neurons with the maximum count.
REQ-027 tie=1 iff two or more neurons share the maximum count.
REQ-028 silent=1 iff all counts are 0; then winner=0 and tie=1.
REQ-029 winner, tie and silent SHALL be computed from the pre-snapshot counters and registered with counts: zero extra latency, no combinational path from spike to outputs.

Reset
REQ-030 On rst_n=0, the following SHALL clear to 0 asynchronously: state=IDLE, len_q, cyc_cnt, all counters, counts, winner, tie, silent, overrun and out_valid.
REQ-031 Reset mid-window SHALL discard the window; the first window after reset release starts per REQ-016.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the default CNT_W and the winner-index width constant.
REQ-033 A single sub-module, spike_argmax (combinational max/lowest-index/tie tree over NUM_NEURONS counts), SHALL be instantiated once.

Verification
REQ-034 Window count: N=2, window_len=4, spike=2'b01 constantly, out_ready=1 -> out_valid pulses every 4 cycles, counts={0,4}, winner=0, tie=0, silent=0.
REQ-035 Saturation: CNT_W=3, window_len=10, spike=2'b11 constantly -> counts={7,7}, tie=1, winner=0.
REQ-036 Back-pressure: window_len=2, out_ready=0 for 2 windows -> second result overwrites the first with overrun=1; after out_ready=1, out_valid clears next edge.
REQ-037 Simultaneous accept and snapshot: out_ready=1 on the snapshot edge -> out_valid stays 1, new counts, overrun=0.
REQ-038 Disable mid-window: window_len=8, ena dropped at cycle 5 -> no out_valid; previous result unchanged; re-enable starts a fresh 8-cycle window.
REQ-039 Async reset: rst_n pulsed low between edges mid-window -> all outputs 0 immediately, no result from the interrupted window.
